vec_chunk_fifo: RTL and testbench

- Chunked vector FIFO; the responder side of the chunk-request interface used by the vector MAC stages.
- The upstream writer pushes one WorkingRegs-wide chunk per accepted write.
- The downstream consumer sees the head chunk first-word-fall-through, pops with a single-cycle request, and is told when at least one complete vector is buffered.
- Sits between pipeline stages, e.g. the previous stage's write_out_data feeds this block, and this block's rd_data/vec_ready feed the next MAC's in_data/in_data_ready.

---
 rtl/vec_chunk_fifo.sv | 119 +++++++++++
 tb/tb_vec_chunk_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vec_chunk_fifo.sv
`default_nettype none
// ============================================================================
// vec_chunk_fifo : chunked FWFT vector FIFO feeding the vector MAC stages.
// Optional macro VEC_CHUNK_FIFO_ERR_FLAGS_EN builds sticky overflow/underflow.
// Revision: 1.0
// ============================================================================
module vec_chunk_fifo #(
  parameter int VecLength   = 16,
  parameter int WorkingRegs = 4,
  parameter int NBits       = 8,
  parameter int DepthVecs   = 2
) (
  input  logic                                                     clk_in,
  input  logic                                                     rst_in,
  input  logic                                                     wr_en,
  input  logic signed [WorkingRegs-1:0][NBits-1:0]                 wr_data,
  output logic                                                     wr_ready,
  input  logic                                                     rd_req,
  output logic signed [WorkingRegs-1:0][NBits-1:0]                 rd_data,
  output logic                                                     rd_valid,
  output logic                                                     rd_last,
  output logic                                                     vec_ready,
  output logic [$clog2(DepthVecs*VecLength/WorkingRegs+1)-1:0]     chunk_count,
  output logic                                                     overflow,
  output logic                                                     underflow
);

  localparam int D      = DepthVecs * VecLength / WorkingRegs;
  localparam int CHUNKS = VecLength / WorkingRegs;
  localparam int PW     = (D > 1) ? $clog2(D) : 1;
  localparam int CW     = $clog2(D + 1);
  localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [PW-1:0] LAST_PTR = PW'(D - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(D);
  localparam logic [CW-1:0] VEC_CNT  = CW'(CHUNKS);

  typedef logic signed [WorkingRegs-1:0][NBits-1:0] chunk_t;

  chunk_t        mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] rd_chunk_idx;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_req && !empty;

  // Storage carries no reset; reads are masked by empty instead.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_chunk_idx <= '0;
      count        <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        rd_chunk_idx <= (rd_chunk_idx == LAST_IDX) ? '0 : rd_chunk_idx + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wr_ready    = !full;
  assign rd_valid    = !empty;
  assign rd_data     = empty ? chunk_t'('0) : mem[rd_ptr];
  assign rd_last     = !empty && (rd_chunk_idx == LAST_IDX);
  assign vec_ready   = (count >= VEC_CNT);
  assign chunk_count = count;

`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
      if (rd_req && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_chunk_fifo.sv
`default_nettype none
// Testbench for vec_chunk_fifo: directed sequences plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_vec_chunk_fifo;

  localparam int VL = 16;
  localparam int WR = 4;
  localparam int NB = 8;
  localparam int DV = 2;
  localparam int D  = DV * VL / WR;
  localparam int CH = VL / WR;

  logic                  clk;
  logic                  rst_in;
  logic                  wr_en;
  logic [WR*NB-1:0]      wr_data;
  logic                  wr_ready;
  logic                  rd_req;
  logic [WR*NB-1:0]      rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  vec_ready;
  logic [$clog2(D+1)-1:0] chunk_count;
  logic                  overflow;
  logic                  underflow;

  vec_chunk_fifo #(
    .VecLength  (VL),
    .WorkingRegs(WR),
    .NBits      (NB),
    .DepthVecs  (DV)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .vec_ready  (vec_ready),
    .chunk_count(chunk_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a plain queue, popped-chunk tally for vector position.
  logic [31:0] exp_q[$];
  int          popped    = 0;
  logic        exp_ovf   = 1'b0;
  logic        exp_unf   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs and inputs are stable at the falling edge.
  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    check("chunk_count", 64'(chunk_count), 64'(sz));
    check("rd_valid", 64'(rd_valid), 64'(sz > 0));
    check("wr_ready", 64'(wr_ready), 64'(sz < D));
    check("vec_ready", 64'(vec_ready), 64'(sz >= CH));
    check("rd_data", 64'(rd_data), (sz > 0) ? 64'(exp_q[0]) : 64'd0);
    check("rd_last", 64'(rd_last), 64'((sz > 0) && (popped % CH == CH - 1)));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("underflow", 64'(underflow), 64'(exp_unf));

    if (rst_in) begin
      exp_q.delete();
      popped  = 0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
      if (wr_en && sz == D) exp_ovf = 1'b1;
      if (rd_req && sz == 0) exp_unf = 1'b1;
`endif
      if (rd_req && sz > 0) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (wr_en && sz < D) exp_q.push_back(wr_data);
    end
  end

  task automatic step(input logic we, input logic [31:0] d, input logic rq);
    wr_en   = we;
    wr_data = d;
    rd_req  = rq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_in  = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_req  = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 32'h0, 1'b0);
    rst_in = 1'b0;

    // One vector in, one vector out
    for (int i = 1; i <= 4; i++) step(1'b1, {4{8'(i)}}, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Overfill by one, then drain
    for (int i = 0; i < 9; i++) step(1'b1, 32'hA0B0C000 + 32'(i), 1'b0);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Simultaneous push/pop at count 5, then drain across the wrap
    for (int i = 0; i < 5; i++) step(1'b1, 32'h11110000 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h22220000 + 32'(i), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Pop while empty, then reset with data stored
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0);
    step(1'b1, 32'hCAFEF00D, 1'b0);
    rst_in = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    rst_in = 1'b0;
    step(1'b0, 32'h0, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst_in = ($urandom_range(0, 99) == 0);
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    rst_in = 1'b0;
    step(1'b0, 32'h0, 1'b0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
